// File: rtl/mips_muldiv_ctrl.sv
// Iterative MIPS HI/LO unit: mul/div done 33 cycles after accept, mthi/mtlo write at the accept edge; start is ignored while busy.
// Optional MIPS_MULDIV_FAST_MULT_EN: mult/multu take a single-cycle product path (done one cycle after accept).
module mips_muldiv_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] src_1,
  input  logic [31:0] src_2,
  input  logic        rd_req,
  output logic        ready,
  output logic        busy,
  output logic        done,
  output logic        div_zero,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FIX = 2'd2} state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [63:0] work_q, work_d;
  logic [31:0] opb_q, opb_d;
  logic        is_div_q, is_div_d;
  logic        neg_p_q, neg_p_d;
  logic        neg_r_q, neg_r_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic        done_q, done_d, dz_q, dz_d;

  logic        accept, op_mul, op_div, s1_neg, s2_neg;
  logic [31:0] mag1, mag2;
  logic [32:0] mul_sum, div_shift;
  logic        div_ge;
  logic [31:0] div_rem;
  logic [63:0] mul_next, div_next, prod_fix;

  assign accept = start & (state_q == IDLE);
  assign op_mul = (op[2:1] == 2'b00);
  assign op_div = (op[2:1] == 2'b01);
  assign s1_neg = op[0] & src_1[31];
  assign s2_neg = op[0] & src_2[31];
  assign mag1   = s1_neg ? (32'd0 - src_1) : src_1;
  assign mag2   = s2_neg ? (32'd0 - src_2) : src_2;

  // work_q is {partial product, multiplier} for mul and {remainder, dividend/quotient} for div
  assign mul_sum   = {1'b0, work_q[63:32]} + (work_q[0] ? {1'b0, opb_q} : 33'd0);
  assign mul_next  = {mul_sum, work_q[31:1]};
  assign div_shift = work_q[63:31];
  assign div_ge    = div_shift >= {1'b0, opb_q};
  assign div_rem   = div_ge ? (div_shift[31:0] - opb_q) : div_shift[31:0];
  assign div_next  = {div_rem, work_q[30:0], div_ge};
  assign prod_fix  = neg_p_q ? (64'd0 - work_q) : work_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept && (op_mul || op_div)) begin
`ifdef MIPS_MULDIV_FAST_MULT_EN
        state_d = op_mul ? FIX : RUN;
`else
        state_d = RUN;
`endif
      end
      RUN:  if (cnt_q == 5'd31) state_d = FIX;
      FIX:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d    = cnt_q;
    work_d   = work_q;
    opb_d    = opb_q;
    is_div_d = is_div_q;
    neg_p_d  = neg_p_q;
    neg_r_d  = neg_r_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = (state_q == FIX);
    dz_d     = (state_q == FIX) & is_div_q & (opb_q == 32'd0);
    if (state_q == IDLE && accept && (op_mul || op_div)) begin
      cnt_d    = 5'd0;
      opb_d    = op_div ? mag2 : mag1;
      is_div_d = op_div;
      // a zero divisor keeps the all-ones quotient unsigned; the remainder still takes the dividend sign
      neg_p_d  = (s1_neg ^ s2_neg) & ~(op_div & (src_2 == 32'd0));
      neg_r_d  = s1_neg;
`ifdef MIPS_MULDIV_FAST_MULT_EN
      work_d   = op_mul ? ({32'd0, mag1} * {32'd0, mag2}) : {32'd0, mag1};
`else
      work_d   = {32'd0, op_div ? mag1 : mag2};
`endif
    end else if (state_q == RUN) begin
      cnt_d  = cnt_q + 5'd1;
      work_d = is_div_q ? div_next : mul_next;
    end else if (state_q == FIX) begin
      if (is_div_q) begin
        lo_d = neg_p_q ? (32'd0 - work_q[31:0])  : work_q[31:0];
        hi_d = neg_r_q ? (32'd0 - work_q[63:32]) : work_q[63:32];
      end else begin
        {hi_d, lo_d} = prod_fix;
      end
    end else if (accept && op == 3'b100) begin
      hi_d = src_1;
    end else if (accept && op == 3'b101) begin
      lo_d = src_1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q    <= 5'd0;
      work_q   <= 64'd0;
      opb_q    <= 32'd0;
      is_div_q <= 1'b0;
      neg_p_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      done_q   <= 1'b0;
      dz_q     <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      work_q   <= work_d;
      opb_q    <= opb_d;
      is_div_q <= is_div_d;
      neg_p_q  <= neg_p_d;
      neg_r_q  <= neg_r_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
      dz_q     <= dz_d;
    end
  end

  always_comb begin
    busy     = (state_q != IDLE);
    ready    = ~busy;
    stall    = rd_req & busy;
    done     = done_q;
    div_zero = dz_q;
    hi       = hi_q;
    lo       = lo_q;
  end

endmodule

// File: doc/mips_muldiv_ctrl.md
MIPS_MULDIV_CTRL -- requirements
Module: mips_muldiv_ctrl

Interface
REQ-001 The block SHALL have the port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-002 The block SHALL have the port reset, input, 1 bit: asynchronous, active-high reset.
REQ-003 The block SHALL have the port start, input, 1 bit: operation request, sampled on clk edges.
REQ-004 The block SHALL have the port op, input, 3 bits: 000 multu, 001 mult, 010 divu, 011 div, 100 mthi, 101 mtlo; 110 and 111 are reserved.
REQ-005 The block SHALL have the port src_1, input, 32 bits: multiplicand, dividend or move source.
REQ-006 The block SHALL have the port src_2, input, 32 bits: multiplier or divisor.
REQ-007 The block SHALL have the port ready, output, 1 bit: high when start will be accepted, equal to !busy.
REQ-008 The block SHALL have the port busy, output, 1 bit: high while a multiply or divide is in flight.
REQ-009 The block SHALL have the port done, output, 1 bit: one-cycle pulse in the cycle after HI/LO is written by a multiply or divide.
REQ-010 The block SHALL have the port div_zero, output, 1 bit: qualifies done; high when the completed divide had a divisor of 0.
REQ-011 The block SHALL have the port rd_req, input, 1 bit: the pipeline wants HI or LO (mfhi/mflo).
REQ-012 The block SHALL have the port stall, output, 1 bit: combinational, equal to rd_req & busy.
REQ-013 The block SHALL have the ports hi and lo, output, 32 bits each: the architectural HI and LO registers.

Function
REQ-014 The block SHALL accept start only when ready=1; start while busy=1 SHALL be ignored without side effects.
REQ-015 The state machine SHALL have the states IDLE, RUN and FIX.
- IDLE -> RUN on an accepted mul/div.
- RUN -> FIX after exactly 32 iterations.
- FIX -> IDLE after one cycle.
REQ-016 An accepted mthi or mtlo SHALL write src_1 into hi or lo at the accepting edge, stay in IDLE, raise neither busy nor done, and leave the other register unchanged.
REQ-017 A reserved op with start SHALL be a no-op.
REQ-018 Accept edge E0: operands are latched and busy=1 from after E0.
- For signed ops, magnitudes and result signs SHALL be captured at E0.
- RUN SHALL perform one iteration per edge, E1..E32.
- FIX SHALL apply sign correction and write HI/LO at E33.
- After E33, busy=0 and done=1 for one cycle.
REQ-019 Multiply SHALL use shift-add, one multiplier bit per iteration; the 64-bit product SHALL go to {hi,lo}.
REQ-020 Divide SHALL use restoring division, one quotient bit per iteration; lo SHALL receive the quotient and hi the remainder.
REQ-021 Signed divide SHALL truncate toward zero, and the remainder SHALL take the dividend's sign.
REQ-022 0x80000000 div 0xFFFFFFFF SHALL give lo=0x80000000 and hi=0.
REQ-023 Divide with src_2=0 SHALL give lo=0xFFFFFFFF and hi=src_1, with div_zero=1 alongside done, and the same 33-cycle latency.
REQ-024 hi and lo SHALL hold their previous values until the FIX edge, so reads while busy return stale data, which stall prevents.
REQ-025 The block SHALL accept a new start in the same cycle that done=1.

Reset
REQ-026 Asserting reset SHALL immediately force state IDLE with hi=0, lo=0, busy=0, done=0 and div_zero=0, aborting any operation in flight with no partial HI/LO write.
REQ-027 After reset deasserts, the block SHALL accept start on the first clk edge.

Configuration
REQ-028 With MIPS_MULDIV_FAST_MULT_EN defined, mult and multu SHALL compute a single-cycle product.
- IDLE -> FIX directly; {hi,lo} written at E1; busy high for one cycle; done after E1.
- Divides SHALL be unchanged.
REQ-029 Without MIPS_MULDIV_FAST_MULT_EN, all multiplies SHALL use the 32-iteration path of REQ-018/REQ-019.

Verification
REQ-030 Scenario: multu with 0xFFFFFFFF, 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001, done 33 cycles after accept (1 cycle with MIPS_MULDIV_FAST_MULT_EN).
REQ-031 Scenario: div with -7 (0xFFFFFFF9), 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; divu with 100, 7 -> lo=14, hi=2.
REQ-032 Scenario: divu with 5, 0 -> lo=0xFFFFFFFF, hi=5, div_zero=1 with done.
REQ-033 Scenario: rd_req=1 during a divide -> stall=1 every busy cycle and 0 the cycle after FIX; start with mthi while busy -> hi unchanged.
REQ-034 Scenario: mtlo 0x1234 then mthi 0xABCD on consecutive cycles -> lo=0x1234, hi=0xABCD, busy never set.
REQ-035 Scenario: reset asserted at RUN iteration 10 of a mult preceded by mthi 0x55 -> hi=0, lo=0, busy=0 immediately; next start accepted on the first edge.
